// File: rtl/fetch_unit.sv
// fetch_unit: ROM fetch sequencer with prefetch FIFO, jump flush, halt and optional range fault (FETCH_LIMIT_EN)
module fetch_unit #(
    parameter int          DEPTH   = 2,
    parameter logic [7:0]  RST_PC  = 8'h00,
    parameter logic [7:0]  ROM_TOP = 8'h1F
) (
    input  logic       clk,
    input  logic       n_reset,
    output logic [7:0] adrs,
    output logic       rd,
    input  logic [7:0] dout,
    output logic [7:0] inst,
    output logic [7:0] pc,
    output logic       inst_valid,
    input  logic       inst_ready,
    input  logic       jmp,
    input  logic [7:0] jmp_adrs,
    input  logic       halt,
    output logic       fault
);
`ifdef FETCH_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {BOOT, RUN, STOP} state_t;
    state_t        state_q;
    logic [7:0]    fptr_q;
    logic [7:0]    data_q [DEPTH];
    logic [7:0]    addr_q [DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [AW:0]   count_q, count_d;
    logic          fault_q, pop, over, take_jmp;
    assign pop        = inst_valid && inst_ready;
    assign over       = LIMIT && (fptr_q > ROM_TOP);
    assign take_jmp   = jmp && (state_q != BOOT);
    assign rd         = (state_q == RUN) && !jmp && !over && ((count_q < FULL) || pop);
    assign count_d    = count_q + (AW+1)'(rd) - (AW+1)'(pop);
    assign adrs       = fptr_q;
    assign inst       = data_q[rptr_q];
    assign pc         = addr_q[rptr_q];
    assign inst_valid = (count_q != '0);
    assign fault      = fault_q;
    // Control FSM, fetch pointer and sticky range fault; a jump overrides everything
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= BOOT;
            fptr_q  <= RST_PC;
            fault_q <= 1'b0;
        end else if (take_jmp) begin
            state_q <= halt ? STOP : RUN;
            fptr_q  <= jmp_adrs;
            fault_q <= 1'b0;
        end else begin
            if (rd) fptr_q <= fptr_q + 8'd1;
            if (state_q == RUN && over) fault_q <= 1'b1;
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     if (halt || over) state_q <= STOP;
                default: if (!halt && !fault_q) state_q <= RUN;
            endcase
        end
    end
    // Prefetch FIFO: push {dout, adrs} on fetch, pop on handshake, flush on jump
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 8'h00;
                addr_q[i] <= 8'h00;
            end
        end else if (take_jmp) begin
            rptr_q  <= wptr_q;
            count_q <= '0;
        end else begin
            if (rd) begin
                data_q[wptr_q] <= dout;
                addr_q[wptr_q] <= fptr_q;
                wptr_q         <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan checks plus randomized run against a queue-based reference model
module tb_fetch_unit;
    localparam int DEPTH = 2;
`ifdef FETCH_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       n_reset, rd, inst_valid, inst_ready, jmp, halt, fault;
    logic [7:0] adrs, dout, inst, pc, jmp_adrs;
    logic [7:0] rom [256];
    int         n_chk = 0;
    int         n_pass = 0;
    bit         m_boot, m_run, m_fault, m_over, m_pop, m_rd;
    logic [7:0] m_ptr;
    logic [15:0] m_q [$];

    fetch_unit #(.DEPTH(DEPTH), .RST_PC(8'h00), .ROM_TOP(8'h1F)) dut (
        .clk(clk), .n_reset(n_reset), .adrs(adrs), .rd(rd), .dout(dout),
        .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .jmp(jmp), .jmp_adrs(jmp_adrs), .halt(halt), .fault(fault)
    );

    always #5 clk = ~clk;
    assign dout = rom[adrs];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: outputs follow from a byte queue, a fetch pointer and run/fault flags
    always @(negedge clk) begin
        if (!n_reset) begin
            chk("rst_rd", 8'(rd), 8'h00);
            chk("rst_valid", 8'(inst_valid), 8'h00);
            chk("rst_fault", 8'(fault), 8'h00);
            chk("rst_adrs", adrs, 8'h00);
            chk("rst_inst", inst, 8'h00);
            chk("rst_pc", pc, 8'h00);
            m_boot = 1'b1;
            m_run = 1'b0;
            m_fault = 1'b0;
            m_ptr = 8'h00;
            m_q.delete();
        end else begin
            m_over = LIMIT && (m_ptr > 8'h1F);
            m_pop = (m_q.size() > 0) && inst_ready;
            m_rd = m_run && !jmp && !m_over && ((m_q.size() < DEPTH) || m_pop);
            chk("adrs", adrs, m_ptr);
            chk("rd", 8'(rd), 8'(m_rd));
            chk("valid", 8'(inst_valid), 8'(m_q.size() > 0));
            chk("fault", 8'(fault), 8'(m_fault));
            if (m_q.size() > 0) begin
                chk("inst", inst, m_q[0][15:8]);
                chk("pc", pc, m_q[0][7:0]);
            end
            if (jmp && !m_boot) begin
                m_q.delete();
                m_ptr = jmp_adrs;
                m_fault = 1'b0;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_rd) begin
                    m_q.push_back({rom[m_ptr], m_ptr});
                    m_ptr = m_ptr + 8'd1;
                end
                if (m_run && m_over) m_fault = 1'b1;
            end
            m_run = m_boot ? 1'b1 : (!halt && !m_fault);
            m_boot = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'h02; rom[1] = 8'h24; rom[2] = 8'h04; rom[3] = 8'h25;
        rom[4] = 8'h05; rom[5] = 8'h27; rom[6] = 8'h06;
        n_reset = 1'b0; inst_ready = 1'b1; jmp = 1'b0; jmp_adrs = 8'h00; halt = 1'b0;
        repeat (2) tick();
        // startup streaming
        n_reset = 1'b1;
        #1 chk("boot_rd", 8'(rd), 8'h00);
        tick(); chk("c1_rd", 8'(rd), 8'h01); chk("c1_adrs", adrs, 8'h00);
        tick(); chk("s_inst0", inst, 8'h02); chk("s_pc0", pc, 8'h00);
        tick(); chk("s_inst1", inst, 8'h24); chk("s_pc1", pc, 8'h01);
        tick(); chk("s_inst2", inst, 8'h04); chk("s_pc2", pc, 8'h02);
        tick(); chk("s_inst3", inst, 8'h25); chk("s_pc3", pc, 8'h03);
        // reset mid-run, between edges
        n_reset = 1'b0;
        #1;
        chk("mr_rd", 8'(rd), 8'h00); chk("mr_valid", 8'(inst_valid), 8'h00);
        chk("mr_fault", 8'(fault), 8'h00); chk("mr_adrs", adrs, 8'h00);
        tick(); n_reset = 1'b1;
        // backpressure
        tick();
        tick(); inst_ready = 1'b0; chk("bp_inst0", inst, 8'h02); chk("bp_pc0", pc, 8'h00);
        tick(); chk("bp_rd_off", 8'(rd), 8'h00);
        repeat (3) tick();
        chk("bp_hold_inst", inst, 8'h02); chk("bp_hold_pc", pc, 8'h00); chk("bp_hold_rd", 8'(rd), 8'h00);
        tick(); inst_ready = 1'b1;
        tick(); chk("bp_inst1", inst, 8'h24); chk("bp_pc1", pc, 8'h01);
        tick(); chk("bp_inst2", inst, 8'h04); chk("bp_pc2", pc, 8'h02);
        // jump with flush
        n_reset = 1'b0;
        tick(); n_reset = 1'b1;
        repeat (3) tick();
        chk("j_head_inst", inst, 8'h24); chk("j_head_pc", pc, 8'h01);
        jmp = 1'b1; jmp_adrs = 8'h05;
        #1 chk("j_rd_off", 8'(rd), 8'h00);
        tick(); jmp = 1'b0;
        #1;
        chk("j_valid_off", 8'(inst_valid), 8'h00); chk("j_rd", 8'(rd), 8'h01); chk("j_adrs", adrs, 8'h05);
        tick(); chk("j_inst0", inst, 8'h27); chk("j_pc0", pc, 8'h05);
        tick(); chk("j_inst1", inst, 8'h06); chk("j_pc1", pc, 8'h06);
        // halt
        halt = 1'b1;
        tick(); chk("h_rd_off", 8'(rd), 8'h00); chk("h_drain_pc", pc, 8'h07);
        tick(); chk("h_valid_off", 8'(inst_valid), 8'h00);
        tick(); halt = 1'b0;
        tick(); chk("h_resume_rd", 8'(rd), 8'h01); chk("h_resume_adrs", adrs, 8'h08);
        tick(); chk("h_resume_pc", pc, 8'h08);
        // range limit / wrap
        jmp = 1'b1; jmp_adrs = LIMIT ? 8'h1E : 8'hFF;
        tick(); jmp = 1'b0;
        chk("r_adrs", adrs, LIMIT ? 8'h1E : 8'hFF);
        tick(); chk("r_pc0", pc, LIMIT ? 8'h1E : 8'hFF);
        tick(); chk("r_pc1", pc, LIMIT ? 8'h1F : 8'h00);
        tick(); chk("r_fault", 8'(fault), LIMIT ? 8'h01 : 8'h00); chk("r_rd", 8'(rd), LIMIT ? 8'h00 : 8'h01);
        jmp = 1'b1; jmp_adrs = 8'h00;
        tick(); jmp = 1'b0; chk("r_clr_fault", 8'(fault), 8'h00);
        tick(); chk("r_inst", inst, 8'h02); chk("r_pc", pc, 8'h00);
        // randomized run, every cycle checked by the model
        repeat (3000) begin
            tick();
            if (!n_reset) n_reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) n_reset = 1'b0;
            inst_ready = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0: jmp_adrs = 8'hFF;
                1: jmp_adrs = 8'hFE;
                default: jmp_adrs = 8'($urandom_range(0, 34));
            endcase
            if ($urandom_range(0, 19) == 0) halt = ~halt;
        end
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer that sits between the CPU core and the program ROM. It initiates ROM reads by driving `adrs`/`rd`, captures the combinational `dout` into a small prefetch FIFO, and hands bytes to the decoder over a valid/ready handshake. It also supports jump redirection with flush, an external halt, and an optional fetch-range fault.

## Interface

- `DEPTH`, 2: prefetch FIFO entries; power of two, 2..8.
- `RST_PC`, 8'h00: first fetch address after reset.
- `ROM_TOP`, 8'h1F: highest populated ROM address; used only with `FETCH_LIMIT_EN`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `n_reset`  in  1: reset, asynchronous and active-low.
- `adrs`  out  8: ROM address; equals the internal fetch pointer.
- `rd`  out  1: ROM read strobe; `dout` is valid in the same cycle.
- `dout`  in  8: ROM read data, combinational from `adrs`/`rd`.
- `inst`  out  8: instruction byte at the FIFO head.
- `pc`  out  8: address that `inst` was fetched from.
- `inst_valid`  out  1: FIFO non-empty.
- `inst_ready`  in  1: core accepts `inst`; a pop occurs when `inst_valid && inst_ready`.
- `jmp`  in  1: redirect request, one cycle.
- `jmp_adrs`  in  8: redirect target.
- `halt`  in  1: level; suspends new fetches.
- `fault`  out  1: sticky fetch-range fault; tied to 0 without the macro.

## Operation

- **States:**
  - BOOT: single cycle after reset release; `rd`=0.
  - RUN: normal fetching.
  - STOP: entered on `halt`=1 or fault; no fetching.
- **Transitions:**
  - BOOT always goes to RUN.
  - RUN goes to STOP on `halt`=1 or fault.
  - STOP goes back to RUN when `halt`=0 and `fault`=0.
  - A jump is taken in any non-BOOT state. It clears `fault`. The next state is RUN if `halt`=0, otherwise STOP.
- **Fetch condition:** `rd` = (state==RUN) && !`jmp` && (count<DEPTH || pop).
  - `rd` is combinational from state, count, `jmp`, `inst_ready`.
- **Fetch action:** on a fetch cycle, the clock edge pushes {`dout`, `adrs`} into the FIFO and increments the fetch pointer.
  - The pointer wraps from 8'hFF to 8'h00; the increment is 8-bit modulo.
- **Jump handling:** `jmp` has priority over push.
  - A handshake completing in the same cycle still counts as consumed.
  - All remaining entries are flushed.
  - Fetch pointer <= `jmp_adrs`.
  - `inst_valid`=0 in the following cycle.
- **Simultaneous push and pop:** count is unchanged; read and write pointers both advance.
- **Halt:** stops new fetches only. Buffered entries remain poppable.
- **Output stability:** `inst`/`pc` are stable while `inst_valid` && !`inst_ready`.

## Timing

- **Reset values (asserted asynchronously):**
  - `adrs`=RST_PC, `rd`=0, `inst_valid`=0, `inst`=8'h00, `pc`=8'h00, `fault`=0.
  - State=BOOT, count=0.
- **Startup:** cycle 0 after release is BOOT. Cycle 1 has `rd`=1 with `adrs`=RST_PC. Cycle 2 has `inst_valid`=1.
- **Fetch latency:** 1 cycle from read to `inst_valid`.
- **Throughput:** 1 byte per cycle with `inst_ready` held high.
- **Jump latency:** `jmp` in cycle n gives `adrs`=`jmp_adrs` with `rd`=1 in n+1, and `inst_valid` in n+2.
- **Reset mid-operation:** FIFO contents are discarded immediately. Restart is from RST_PC as above.

## Configuration

- **`FETCH_LIMIT_EN` defined:**
  - When the fetch pointer exceeds ROM_TOP, no read is issued.
  - `fault` rises at the next edge; the state goes to STOP.
  - Entries already buffered remain poppable.
  - `fault` stays 1 until a jump or reset.
- **`FETCH_LIMIT_EN` undefined:**
  - `fault` is constant 0 and ROM_TOP is ignored.
  - Fetching covers the full 8-bit space with wrap-around.

## Test plan

Program ROM contents: 02,24,04,25,05,27,06 at 00..06, 00 elsewhere in 00..1F. DEPTH=2, RST_PC=00.

- **Startup streaming:** release reset with `inst_ready`=1. Required: `inst`/`pc` = 02/00, 24/01, 04/02, 25/03 on consecutive cycles starting at cycle 2.
- **Backpressure:** hold `inst_ready`=0 from cycle 2 for 5 cycles. Required: `rd` drops after 2 buffered fetches; `inst`=02, `pc`=00 held. On release: 24/01 and 04/02 follow with no loss or duplicate.
- **Jump with flush:** `jmp`=1, `jmp_adrs`=05 while 24/01 is at the FIFO head. Required: `inst_valid`=0 for one cycle, then 27/05 followed by 06/06. No stale 04/25 appears.
- **Halt:** `halt`=1 while streaming. Required: `rd`=0 next cycle, buffered bytes still drain, `inst_valid` falls. On `halt`=0: fetching resumes at the next sequential address.
- **Range limit:**
  - With `FETCH_LIMIT_EN`: jump to 1E. Required: bytes from 1E and 1F delivered, then `fault`=1 and `rd`=0. A jump to 00 then clears `fault` and delivers 02/00.
  - Without the macro: jump to FF. Required: `pc` FF then 00 (wrap), `fault`=0.
- **Reset mid-run:** assert `n_reset`=0 mid-stream, between edges. Required: `rd`, `inst_valid` and `fault` go to 0 and `adrs` to 00 immediately. After release the sequence restarts at 02/00.
